// File: rtl/tdm_demux_1_16.sv
// Serial-to-parallel TDM demultiplexer: rebuilds an N_CH-bit word from one bit per slot.
// Optional trailing even-parity bit per frame when TDM_PARITY_EN is defined.
module tdm_demux_1_16 #(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] sel_out,
  output logic [0:N_CH-1]  out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PARITY
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

  state_t            state;
  logic [0:N_CH-1]   shadow;

  assign busy = (state != IDLE);

  // NOTE: shadow is reset along with the rest so a reset mid-frame leaves no stale bits;
  // it is only N_CH flops, not a memory macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_out   <= '0;
      shadow    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere so every read below sees pre-edge values.
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (in_valid) begin
        if (frame_start) begin
          // A new frame start always wins; mid-frame it aborts the partial frame.
          if (state != IDLE) frame_err <= 1'b1;
          shadow[0] <= in;
          sel_out   <= SEL_W'(1);
          state     <= COLLECT;
        end else begin
          case (state)
            IDLE: ;
            COLLECT: begin
              shadow[sel_out] <= in;
              sel_out         <= sel_out + 1'b1;
              if (sel_out == LAST_SLOT) begin
`ifdef TDM_PARITY_EN
                state <= PARITY;
`else
                out       <= {shadow[0:N_CH-2], in};
                out_valid <= 1'b1;
                state     <= IDLE;
`endif
              end
            end
`ifdef TDM_PARITY_EN
            PARITY: begin
              // Even parity: the parity bit equals the XOR of the data bits.
              if (in == ^shadow) begin
                out       <= shadow;
                out_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              sel_out <= '0;
              state   <= IDLE;
            end
`endif
            default: begin
              sel_out <= '0;
              state   <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_16.sv
// Self-checking bench for tdm_demux_1_16: directed scenarios plus random frames,
// compared every cycle against a queue-based frame model.
module tb_tdm_demux_1_16;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         in_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [3:0]   sel_out;
  logic [0:N-1] dout;
  logic         out_valid;
  logic         busy;
  logic         frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ov_n = 0;
  int ov_last = 0;
  bit track_gap = 1'b0;

  // Reference model: bits of the frame in progress, oldest (slot 0) first.
  bit          q[$];
  bit          active;
  bit          par_phase;
  logic [15:0] m_out;
  bit          m_ov;
  bit          m_fe;

  always #5 clk = ~clk;

  tdm_demux_1_16 dut (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .frame_start(frame_start),
    .sel_out(sel_out), .out(dout), .out_valid(out_valid), .busy(busy), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] q_word();
    logic [15:0] w = '0;
    for (int k = 0; k < N; k++) w[N-1-k] = q[k];
    return w;
  endfunction

  function automatic bit q_xor();
    bit p = 1'b0;
    foreach (q[k]) p ^= q[k];
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    active = 1'b0; par_phase = 1'b0;
    m_out = '0; m_ov = 1'b0; m_fe = 1'b0;
  endtask

  task automatic check_all();
    check("sel_out",   32'(sel_out),   32'(active ? (q.size() % N) : 0));
    check("out",       32'(dout),      32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("busy",      32'(busy),      32'(active));
    check("frame_err", 32'(frame_err), 32'(m_fe));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit iv, input bit fs, input bit b);
    din = b; in_valid = iv; frame_start = fs;
    m_ov = 1'b0; m_fe = 1'b0;
    if (iv) begin
      if (fs) begin
        m_fe = active;
        q.delete(); q.push_back(b);
        active = 1'b1; par_phase = 1'b0;
      end else if (active) begin
        if (par_phase) begin
          if (b == q_xor()) begin m_out = q_word(); m_ov = 1'b1; end
          else m_fe = 1'b1;
          q.delete(); active = 1'b0; par_phase = 1'b0;
        end else begin
          q.push_back(b);
          if (q.size() == N) begin
`ifdef TDM_PARITY_EN
            par_phase = 1'b1;
`else
            m_out = q_word(); m_ov = 1'b1;
            q.delete(); active = 1'b0;
`endif
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    if (out_valid) begin
      if (track_gap && ov_n > 0) check("ov_gap", 32'(cyc - ov_last), 32'd16);
      ov_n++;
      ov_last = cyc;
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_part(input logic [15:0] w, input int n, input int stall_pct);
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(99)) < stall_pct) stall(1);
      step(1'b1, k == 0, w[N-1-k]);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int stall_pct, input bit good_par);
    send_part(w, N, stall_pct);
`ifdef TDM_PARITY_EN
    step(1'b1, 1'b0, good_par ? ^w : ~^w);
`endif
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-frame after slot 5, then a clean frame.
    send_part(16'h1234, 6, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    in_valid = 1'b0;
    rst_n = 1'b1;
    send_frame(16'h1234, 0, 1'b1);
    check("out_1234", 32'(dout), 32'h1234);

    // Continuous frame.
    send_frame(16'hA5C3, 0, 1'b1);
    check("out_a5c3", 32'(dout), 32'hA5C3);

    // Stall three cycles after slot 7.
    send_part(16'hA5C3, 8, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check("stall_sel", 32'(sel_out), 32'd8);
      check("stall_busy", 32'(busy), 32'd1);
    end
    for (int k = 8; k < N; k++) step(1'b1, 1'b0, 1'(16'hA5C3 >> (N - 1 - k)));
`ifdef TDM_PARITY_EN
    step(1'b1, 1'b0, ^16'hA5C3);
`endif
    check("stall_out", 32'(dout), 32'hA5C3);

    // Walking one, back to back.
    ov_n = 0;
    track_gap = 1'b1;
    for (int i = 0; i < N; i++) send_frame(16'h8000 >> i, 0, 1'b1);
    track_gap = 1'b0;
`ifndef TDM_PARITY_EN
    check("walk_pulses", 32'(ov_n), 32'd16);
`endif
    check("walk_last", 32'(dout), 32'h0001);

    // Abort at slot 9 after a committed word.
    send_frame(16'h00FF, 0, 1'b1);
    send_part(16'hFFFF, 9, 0);
    step(1'b1, 1'b1, 1'b0);
    check("abort_err", 32'(frame_err), 32'd1);
    check("abort_hold", 32'(dout), 32'h00FF);
    for (int k = 1; k < N; k++) step(1'b1, 1'b0, 1'(16'h0F0F >> (N - 1 - k)));
`ifdef TDM_PARITY_EN
    step(1'b1, 1'b0, ^16'h0F0F);
`endif
    check("restart_out", 32'(dout), 32'h0F0F);

`ifdef TDM_PARITY_EN
    send_frame(16'h0001, 0, 1'b1);
    check("par_good", 32'(dout), 32'h0001);
    send_frame(16'h0F0F, 0, 1'b1);
    send_frame(16'h0001, 0, 1'b0);
    check("par_bad_err", 32'(frame_err), 32'd1);
    check("par_bad_hold", 32'(dout), 32'h0F0F);
`endif

    // Random traffic: idle noise, stalls, aborts, bad parity.
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(3))
        0: for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom));
        1: begin
          send_part(16'($urandom), $urandom_range(1, N - 1), 15);
          send_frame(16'($urandom), 15, 1'b1);
        end
        default: send_frame(16'($urandom), 20, ($urandom_range(4) != 0));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
